// File: rtl/memory_stage_pkg.sv
// Shared constants for the memory stage: operation classes, access sizes
// and the controller state encoding.
package memory_stage_pkg;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/memory_stage_align.sv
// Combinational lane logic: byte enables, store replication, load
// extraction with zero/sign extension, and misalignment detection.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rdata[{addr, 3'b000} +: 8];
        half_lane  = addr[1] ? rdata[31:16] : rdata[15:0];
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr;
                wdata     = {4{store_data[7:0]}};
                load_data = is_unsigned ? {24'h0, byte_lane}
                                        : {{24{byte_lane[7]}}, byte_lane};
            end
            SIZE_HALF: begin
                misaligned = addr[0];
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = is_unsigned ? {16'h0, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                // Size 2'b11 is not a defined encoding; it behaves as a word.
                misaligned = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU results through and performs single
// load/store transactions on a req/ack data bus with valid/next handshakes.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [BITSIZE-1:0] ex_data_i,
    input  logic [BITSIZE-1:0] ex_store_data_i,
    input  logic [4:0]         ex_rd_i,
    input  logic [6:0]         ex_operation_i,
    input  logic               ex_valid_i,
    output logic               ex_next_o,
    output logic [BITSIZE-1:0] wb_data_o,
    output logic [4:0]         wb_rd_o,
    output logic               wb_valid_o,
    input  logic               wb_next_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    output logic [BITSIZE-1:0] mem_wdata_o,
    output logic [3:0]         mem_be_o,
    input  logic               mem_ack_i,
    input  logic [BITSIZE-1:0] mem_rdata_i,
    output logic               misaligned_o
);

    generate
        if (BITSIZE != 32) begin : g_bad_bitsize
            $error("memory_stage: BITSIZE must be 32");
        end
    endgenerate

    state_t              state_reg, state_next;
    logic                mem_req_reg, mem_we_reg, misaligned_reg, load_reg, uns_reg;
    logic [BITSIZE-1:0]  mem_addr_reg, mem_wdata_reg, wb_data_reg;
    logic [3:0]          mem_be_reg;
    logic [4:0]          wb_rd_reg, rd_reg;
    logic [1:0]          addr_lo_reg, size_reg;

    logic [2:0]  op_class;
    logic        is_load, is_store, is_mem, accept, in_bus;
    logic [1:0]  al_addr, al_size;
    logic        al_uns, al_misaligned;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        unused_op_bit;

    assign op_class      = ex_operation_i[6:4];
    assign is_load       = (op_class == OP_LOAD);
    assign is_store      = (op_class == OP_STORE);
    assign is_mem        = is_load | is_store;
    assign unused_op_bit = ex_operation_i[3];

    assign ex_next_o  = (state_reg == IDLE) | ((state_reg == RESP) & wb_next_i);
    assign accept     = ex_valid_i & ex_next_o;
    assign wb_valid_o = (state_reg == RESP);
    assign in_bus     = (state_reg == BUS);

    // During BUS the aligner decodes the latched access; otherwise the incoming one.
    assign al_addr = in_bus ? addr_lo_reg : ex_data_i[1:0];
    assign al_size = in_bus ? size_reg    : ex_operation_i[1:0];
    assign al_uns  = in_bus ? uns_reg     : ex_operation_i[2];

    mem_align u_align (
        .addr        (al_addr),
        .size        (al_size),
        .is_unsigned (al_uns),
        .store_data  (ex_store_data_i),
        .rdata       (mem_rdata_i),
        .be          (al_be),
        .wdata       (al_wdata),
        .load_data   (al_load),
        .misaligned  (al_misaligned)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (accept)
                    state_next = (is_mem && !al_misaligned) ? BUS : RESP;
                else if (state_reg == RESP && wb_next_i)
                    state_next = IDLE;
            end
            BUS:     if (mem_ack_i) state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= 4'b0000;
            wb_data_reg    <= '0;
            wb_rd_reg      <= 5'd0;
            misaligned_reg <= 1'b0;
            rd_reg         <= 5'd0;
            addr_lo_reg    <= 2'b00;
            size_reg       <= 2'b00;
            uns_reg        <= 1'b0;
            load_reg       <= 1'b0;
        end else begin
            misaligned_reg <= 1'b0;
            if (accept) begin
                rd_reg      <= ex_rd_i;
                addr_lo_reg <= ex_data_i[1:0];
                size_reg    <= ex_operation_i[1:0];
                uns_reg     <= ex_operation_i[2];
                load_reg    <= is_load;
                if (is_mem && al_misaligned) begin
                    misaligned_reg <= 1'b1;
                    wb_data_reg    <= '0;
                    wb_rd_reg      <= 5'd0;
                end else if (is_mem) begin
                    mem_req_reg   <= 1'b1;
                    mem_we_reg    <= is_store;
                    mem_addr_reg  <= {ex_data_i[BITSIZE-1:2], 2'b00};
                    mem_be_reg    <= al_be;
                    mem_wdata_reg <= al_wdata;
                end else begin
                    wb_data_reg <= ex_data_i;
                    wb_rd_reg   <= ex_rd_i;
                end
            end else if (in_bus && mem_ack_i) begin
                mem_req_reg <= 1'b0;
                wb_data_reg <= load_reg ? al_load : '0;
                wb_rd_reg   <= load_reg ? rd_reg : 5'd0;
            end
        end
    end

    assign mem_req_o    = mem_req_reg;
    assign mem_we_o     = mem_we_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_wdata_o  = mem_wdata_reg;
    assign mem_be_o     = mem_be_reg;
    assign wb_data_o    = wb_data_reg;
    assign wb_rd_o      = wb_rd_reg;
    assign misaligned_o = misaligned_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed cases, randomized op stream,
// a bus responder with its own memory image, and a writeback monitor.
module tb_memory_stage;

    typedef struct { logic [31:0] data; logic [4:0] rd; logic mis; } wb_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;

    logic        clk = 1'b0, rstn = 1'b0;
    logic [31:0] ex_data = '0, ex_store_data = '0, mem_rdata = '0;
    logic [4:0]  ex_rd = '0;
    logic [6:0]  ex_operation = '0;
    logic        ex_valid = 1'b0, wb_next = 1'b0, mem_ack = 1'b0;
    logic        ex_next, wb_valid, mem_req, mem_we, misaligned;
    logic [31:0] wb_data, mem_addr, mem_wdata;
    logic [4:0]  wb_rd;
    logic [3:0]  mem_be;

    int checks = 0, failures = 0, cyc = 0;
    int wb_next_mode = 1;   // 0 random, 1 always ready, 2 stall
    int ack_delay = 0;      // 0 random ack, N ack in the N-th request cycle
    bit stray_all = 1'b0;
    wb_t  wb_q[$];
    bus_t bus_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] resp_mem[16];

    memory_stage #(.BITSIZE(32)) dut (
        .clk(clk), .rstn(rstn),
        .ex_data_i(ex_data), .ex_store_data_i(ex_store_data), .ex_rd_i(ex_rd),
        .ex_operation_i(ex_operation), .ex_valid_i(ex_valid), .ex_next_o(ex_next),
        .wb_data_o(wb_data), .wb_rd_o(wb_rd), .wb_valid_o(wb_valid), .wb_next_i(wb_next),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .misaligned_o(misaligned)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference behaviour from the access rules: lane arithmetic on a word image.
    function automatic void model(input logic [6:0] op, input logic [31:0] d, input logic [31:0] sd,
                                  input logic [4:0] rd, output wb_t w, output logic hb, output bus_t b);
        int nb, a, idx;
        logic [31:0] word, mask, v;
        a   = int'(d[1:0]);
        idx = int'(d[5:2]);
        nb  = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        hb  = 1'b0;
        b   = '{1'b0, 32'h0, 4'h0, 32'h0};
        w   = '{d, rd, 1'b0};
        if (op[6:4] == 3'b001 || op[6:4] == 3'b010) begin
            if (a % nb != 0) begin
                w = '{32'h0, 5'd0, 1'b1};
            end else begin
                hb      = 1'b1;
                b.we    = (op[6:4] == 3'b010);
                b.addr  = d & ~32'h3;
                b.be    = 4'(((1 << nb) - 1) << a);
                mask    = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
                b.wdata = (nb == 1) ? sd[7:0] * 32'h0101_0101 :
                          (nb == 2) ? sd[15:0] * 32'h0001_0001 : sd;
                if (b.we) begin
                    word = ref_mem[idx];
                    for (int i = 0; i < nb; i++) word[8*(a+i) +: 8] = sd[8*i +: 8];
                    ref_mem[idx] = word;
                    w = '{32'h0, 5'd0, 1'b0};
                end else begin
                    v = (ref_mem[idx] >> (8 * a)) & mask;
                    if (!op[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
                    w = '{v, rd, 1'b0};
                end
            end
        end
    endfunction

    // Called at negedge+1; returns at negedge+1 after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [31:0] d, input logic [31:0] sd,
                        input logic [4:0] rd, input wb_t w, input logic hb, input bus_t b);
        int n = 0;
        wb_q.push_back(w);
        if (hb) bus_q.push_back(b);
        ex_operation = op; ex_data = d; ex_store_data = sd; ex_rd = rd; ex_valid = 1'b1;
        #1;
        while (!ex_next) begin
            n++;
            if (n > 500) begin
                $display("FAIL accept_timeout actual=%h required=%h", 0, 1);
                $fatal(1, "accept timeout");
            end
            @(negedge clk); #2;
        end
        @(negedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic send_model(input logic [6:0] op, input logic [31:0] d, input logic [31:0] sd,
                              input logic [4:0] rd);
        wb_t w; logic hb; bus_t b;
        model(op, d, sd, rd, w, hb, b);
        send(op, d, sd, rd, w, hb, b);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((wb_q.size() != 0 || bus_q.size() != 0) && n < 2000) begin
            @(negedge clk); #1; n++;
        end
        chk("drain_timeout", 32'(wb_q.size() + bus_q.size()), 32'h0);
    endtask

    // Writeback monitor: compares the queue head every valid cycle, pops on transfer.
    initial begin
        bit new_item = 1'b1;
        forever begin
            @(negedge clk); #1;
            if (!rstn) begin new_item = 1'b1; wb_next = 1'b0; continue; end
            if (wb_valid) begin
                if (wb_q.size() == 0) chk("wb_unexpected", 32'(wb_valid), 32'h0);
                else begin
                    chk("wb_data", wb_data, wb_q[0].data);
                    chk("wb_rd", 32'(wb_rd), 32'(wb_q[0].rd));
                    chk("misaligned", 32'(misaligned), new_item ? 32'(wb_q[0].mis) : 32'h0);
                end
            end else chk("misaligned_idle", 32'(misaligned), 32'h0);
            wb_next = (wb_next_mode == 1) ? 1'b1 :
                      (wb_next_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
            if (wb_valid && wb_next && wb_q.size() != 0) begin
                void'(wb_q.pop_front());
                new_item = 1'b1;
            end else if (wb_valid) new_item = 1'b0;
            #1;
            chk("ex_next", 32'(ex_next), wb_valid ? 32'(wb_next) : 32'(!mem_req));
        end
    end

    // Bus responder with its own memory image.
    initial begin
        bit new_req = 1'b1;
        int cnt = 0;
        bus_t cur;
        forever begin
            @(negedge clk); #1;
            if (!rstn) begin new_req = 1'b1; mem_ack = 1'b0; continue; end
            if (mem_req) begin
                if (new_req) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", 32'(mem_req), 32'h0);
                        cur = '{mem_we, mem_addr, mem_be, mem_wdata};
                    end else begin
                        cur = bus_q.pop_front();
                        chk("bus_we", 32'(mem_we), 32'(cur.we));
                        chk("bus_addr", mem_addr, cur.addr);
                        chk("bus_be", 32'(mem_be), 32'(cur.be));
                        if (cur.we) chk("bus_wdata", mem_wdata, cur.wdata);
                    end
                    new_req = 1'b0;
                    cnt = 0;
                end else begin
                    chk("bus_hold_addr", mem_addr, cur.addr);
                    chk("bus_hold_ctl", {27'h0, mem_we, mem_be}, {27'h0, cur.we, cur.be});
                    if (cur.we) chk("bus_hold_wdata", mem_wdata, cur.wdata);
                end
                cnt++;
                mem_ack   = (ack_delay > 0) ? (cnt >= ack_delay) : ($urandom_range(0, 9) < 4);
                mem_rdata = resp_mem[mem_addr[5:2]];
                if (mem_ack) begin
                    if (mem_we)
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) resp_mem[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                    new_req = 1'b1;
                end
            end else begin
                mem_ack   = stray_all ? 1'b1 : ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=%0d required=%0d", cyc, 0);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  op;
        logic [31:0] d;
        logic [2:0]  cls;
        int          pick, t0, t1;
        for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; resp_mem[i] = ref_mem[i]; end

        // Reset values
        #3;
        chk("rst_mem_req", 32'(mem_req), 0);   chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_be", 32'(mem_be), 0);     chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_misaligned", 32'(misaligned), 0);
        chk("rst_mem_addr", mem_addr, 0);      chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ex_next", 32'(ex_next), 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #1;

        // Pass-through and back-to-back throughput, including an unknown class
        wb_next_mode = 1;
        send(7'b000_0000, 32'h1234_5678, 32'h0, 5'd5, '{32'h1234_5678, 5'd5, 1'b0}, 1'b0, '{0, 0, 0, 0});
        t0 = cyc;
        send(7'b111_0000, 32'h0BAD_F00D, 32'h0, 5'd7, '{32'h0BAD_F00D, 5'd7, 1'b0}, 1'b0, '{0, 0, 0, 0});
        t1 = cyc;
        chk("back_to_back_gap", 32'(t1 - t0), 32'h1);
        wait_drain();

        // Signed byte load from 0x103, ack in the third request cycle
        ref_mem[0] = 32'h80FF_FFFF; resp_mem[0] = 32'h80FF_FFFF;
        ack_delay = 3;
        send(7'b001_0000, 32'h0000_0103, 32'h0, 5'd12, '{32'hFFFF_FF80, 5'd12, 1'b0},
             1'b1, '{1'b0, 32'h0000_0100, 4'b1000, 32'h0});
        wait_drain();

        // Half store to 0x202 with immediate ack
        ack_delay = 1;
        send(7'b010_0001, 32'h0000_0202, 32'h0000_ABCD, 5'd9, '{32'h0, 5'd0, 1'b0},
             1'b1, '{1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD});
        ref_mem[0][31:16] = 16'hABCD;
        wait_drain();

        // Misaligned word load: no bus request
        send(7'b001_0010, 32'h0000_0101, 32'h0, 5'd3, '{32'h0, 5'd0, 1'b1}, 1'b0, '{0, 0, 0, 0});
        wait_drain();

        // Randomized stream with random stalls and ack latency
        wb_next_mode = 0;
        ack_delay    = 0;
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            cls  = (pick < 3) ? 3'b000 : (pick < 6) ? 3'b001 : (pick < 9) ? 3'b010
                                                    : 3'($urandom_range(3, 7));
            op   = {cls, 1'($urandom), 1'($urandom), 2'($urandom_range(0, 2))};
            d    = (cls == 3'b001 || cls == 3'b010) ? 32'h100 + 32'($urandom_range(0, 63)) : $urandom;
            send_model(op, d, $urandom, 5'($urandom));
            if ($urandom_range(0, 5) == 0) begin @(negedge clk); #1; end
        end
        wait_drain();

        // Stalled writeback holds outputs and blocks upstream
        wb_next_mode = 2;
        send(7'b000_0000, 32'hCAFE_0001, 32'h0, 5'd17, '{32'hCAFE_0001, 5'd17, 1'b0}, 1'b0, '{0, 0, 0, 0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            chk("hold_ex_next", 32'(ex_next), 0);
            chk("hold_wb_valid", 32'(wb_valid), 1);
        end
        wb_next_mode = 1;
        wait_drain();

        // Reset during BUS abandons the transaction; stray acks are ignored afterwards
        ack_delay = 1000;
        send_model(7'b001_0010, 32'h0000_0104, 32'h0, 5'd4);
        pick = 0;
        while (!mem_req && pick < 20) begin @(negedge clk); #2; pick++; end
        chk("bus_entered", 32'(mem_req), 1);
        rstn = 1'b0;
        #1;
        chk("rst_bus_req", 32'(mem_req), 0);
        chk("rst_bus_ex_next", 32'(ex_next), 1);
        wb_q.delete();
        bus_q.delete();
        repeat (2) @(negedge clk);
        stray_all = 1'b1;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #3;
            chk("stray_ack_req", 32'(mem_req), 0);
            chk("stray_ack_valid", 32'(wb_valid), 0);
        end
        stray_all = 1'b0;
        ack_delay = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
